// File: rtl/minibus_router_if.sv
// -----------------------------------------------------------------------------
// minibus_router_if
// Bundles the minibus signals seen by the router.
//   map_start/map_end : per-slave address windows, packed [i*AW +: AW]
//   m_req_* / m_res_* : master request and response channel
//   s_req_* / s_res_* : fan-out request and per-slave response channel
// Modports:
//   master : the bus master (drives requests and the map, sees responses)
//   slave  : the slave devices (see requests, drive responses)
//   router : the router itself
// -----------------------------------------------------------------------------
interface minibus_router_if #(
    parameter int SLAVE_COUNT = 4,
    parameter int AW          = 32,
    parameter int DW          = 32
);
    logic [SLAVE_COUNT*AW-1:0] map_start;
    logic [SLAVE_COUNT*AW-1:0] map_end;

    logic                      m_req_valid;
    logic                      m_req_ready;
    logic [AW-1:0]             m_req_addr;
    logic                      m_req_wen;
    logic [DW-1:0]             m_req_wdata;
    logic [DW/8-1:0]           m_req_wstrb;
    logic                      m_res_valid;
    logic [DW-1:0]             m_res_rdata;
    logic                      m_res_err;

    logic [SLAVE_COUNT-1:0]    s_req_valid;
    logic [SLAVE_COUNT-1:0]    s_req_ready;
    logic [AW-1:0]             s_req_addr;
    logic                      s_req_wen;
    logic [DW-1:0]             s_req_wdata;
    logic [DW/8-1:0]           s_req_wstrb;
    logic [SLAVE_COUNT-1:0]    s_res_valid;
    logic [SLAVE_COUNT*DW-1:0] s_res_rdata;
    logic [SLAVE_COUNT-1:0]    s_res_err;

    modport master (
        output map_start, map_end,
        output m_req_valid, m_req_addr, m_req_wen, m_req_wdata, m_req_wstrb,
        input  m_req_ready, m_res_valid, m_res_rdata, m_res_err
    );

    modport slave (
        input  s_req_valid, s_req_addr, s_req_wen, s_req_wdata, s_req_wstrb,
        output s_req_ready, s_res_valid, s_res_rdata, s_res_err
    );

    modport router (
        input  map_start, map_end,
        input  m_req_valid, m_req_addr, m_req_wen, m_req_wdata, m_req_wstrb,
        output m_req_ready, m_res_valid, m_res_rdata, m_res_err,
        output s_req_valid, s_req_addr, s_req_wen, s_req_wdata, s_req_wstrb,
        input  s_req_ready, s_res_valid, s_res_rdata, s_res_err
    );
endinterface

// File: rtl/minibus_router.sv
// -----------------------------------------------------------------------------
// minibus_router
// Registered single-outstanding address router: one master, SLAVE_COUNT slaves
// with runtime-programmable half-open windows [start, end). Unmapped addresses
// and slaves that stay silent for TIMEOUT cycles get an error response carrying
// ERR_DATA.
// Ports:
//   clk  : clock, rising edge
//   nrst : asynchronous active-low reset
//   bus  : minibus_router_if.router (map, master channel, slave fan-out)
// -----------------------------------------------------------------------------
module minibus_router #(
    parameter int          SLAVE_COUNT = 4,
    parameter int          AW          = 32,
    parameter int          DW          = 32,
    parameter int          TIMEOUT     = 255,
    parameter logic [31:0] ERR_DATA    = 32'hDEAD_BEEF
) (
    input  logic             clk,
    input  logic             nrst,
    minibus_router_if.router bus
);
    localparam int            SW       = DW / 8;
    localparam int            TW       = (SLAVE_COUNT > 1) ? $clog2(SLAVE_COUNT) : 1;
    localparam int            CW       = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [DW-1:0] ERR_WORD = DW'(ERR_DATA);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    state_t                 r_state;
    state_t                 w_next;

    logic [AW-1:0]          r_addr;
    logic                   r_wen;
    logic [DW-1:0]          r_wdata;
    logic [SW-1:0]          r_wstrb;
    logic [TW-1:0]          r_tgt;
    logic [CW-1:0]          r_cnt;
    logic [SLAVE_COUNT-1:0] r_s_req_valid;
    logic                   r_m_res_valid;
    logic                   r_m_res_err;
    logic [DW-1:0]          r_m_res_rdata;

    logic                   w_ready;
    logic                   w_accept;
    logic                   w_dec_hit;
    logic [TW-1:0]          w_dec_idx;
    logic [TW-1:0]          w_tgt_next;
    logic [SLAVE_COUNT-1:0] w_tgt_onehot;
    logic                   w_tgt_req_ready;
    logic                   w_tgt_res_valid;
    logic                   w_tgt_res_err;
    logic [DW-1:0]          w_tgt_res_rdata;
    logic                   w_timeout;
    logic                   w_load_res;
    logic                   w_res_err;
    logic [DW-1:0]          w_res_rdata;

    // Ready decodes from the state register but is forced low while reset is held.
    assign w_ready  = (r_state == ST_IDLE) & nrst;
    assign w_accept = bus.m_req_valid & w_ready;

    // The counter only ever reaches TIMEOUT while in ISSUE/WAIT; TIMEOUT of 0 disables it.
    assign w_timeout = (TIMEOUT != 0) && (r_cnt == CW'(TIMEOUT));

    // Target index used for the s_req_valid register: fresh decode on acceptance, else held.
    assign w_tgt_next = w_accept ? w_dec_idx : r_tgt;

    // Address decode; scanning from the top down lets the lowest matching index win.
    always_comb begin
        w_dec_hit = 1'b0;
        w_dec_idx = {TW{1'b0}};
        for (int i = SLAVE_COUNT - 1; i >= 0; i--) begin
            // start >= end can never satisfy both bounds, so empty windows never hit.
            if ((bus.map_start[i*AW +: AW] <= bus.m_req_addr) &&
                (bus.m_req_addr < bus.map_end[i*AW +: AW])) begin
                w_dec_hit = 1'b1;
                w_dec_idx = TW'(i);
            end else begin
            end
        end
    end

    // Select handshake and response signals of the latched target only.
    always_comb begin
        w_tgt_req_ready = 1'b0;
        w_tgt_res_valid = 1'b0;
        w_tgt_res_err   = 1'b0;
        w_tgt_res_rdata = {DW{1'b0}};
        for (int i = 0; i < SLAVE_COUNT; i++) begin
            if (TW'(i) == r_tgt) begin
                w_tgt_req_ready = bus.s_req_ready[i];
                w_tgt_res_valid = bus.s_res_valid[i];
                w_tgt_res_err   = bus.s_res_err[i];
                w_tgt_res_rdata = bus.s_res_rdata[i*DW +: DW];
            end else begin
            end
        end
    end

    // One-hot request vector for the target that will be in ISSUE next cycle.
    always_comb begin
        w_tgt_onehot = {SLAVE_COUNT{1'b0}};
        for (int i = 0; i < SLAVE_COUNT; i++) begin
            w_tgt_onehot[i] = (TW'(i) == w_tgt_next);
        end
    end

    // Next-state and response-capture decisions.
    always_comb begin
        w_next      = r_state;
        w_load_res  = 1'b0;
        w_res_err   = 1'b0;
        w_res_rdata = ERR_WORD;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    if (w_dec_hit) begin
                        w_next = ST_ISSUE;
                    end else begin
                        w_next      = ST_RESP;
                        w_load_res  = 1'b1;
                        w_res_err   = 1'b1;
                        w_res_rdata = ERR_WORD;
                    end
                end else begin
                    w_next = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                // A ready coinciding with the timeout still times out: no response can exist yet.
                if (w_timeout) begin
                    w_next      = ST_RESP;
                    w_load_res  = 1'b1;
                    w_res_err   = 1'b1;
                    w_res_rdata = ERR_WORD;
                end else if (w_tgt_req_ready) begin
                    w_next = ST_WAIT;
                end else begin
                    w_next = ST_ISSUE;
                end
            end
            ST_WAIT: begin
                // A slave response in the timeout cycle takes priority over the timeout.
                if (w_tgt_res_valid) begin
                    w_next      = ST_RESP;
                    w_load_res  = 1'b1;
                    w_res_err   = w_tgt_res_err;
                    w_res_rdata = w_tgt_res_rdata;
                end else if (w_timeout) begin
                    w_next      = ST_RESP;
                    w_load_res  = 1'b1;
                    w_res_err   = 1'b1;
                    w_res_rdata = ERR_WORD;
                end else begin
                    w_next = ST_WAIT;
                end
            end
            ST_RESP: begin
                w_next = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Request latch; these registers also drive the shared s_req_* outputs.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_addr  <= {AW{1'b0}};
            r_wen   <= 1'b0;
            r_wdata <= {DW{1'b0}};
            r_wstrb <= {SW{1'b0}};
            r_tgt   <= {TW{1'b0}};
        end else if (w_accept) begin
            r_addr  <= bus.m_req_addr;
            r_wen   <= bus.m_req_wen;
            r_wdata <= bus.m_req_wdata;
            r_wstrb <= bus.m_req_wstrb;
            r_tgt   <= w_dec_idx;
        end
    end

    // Timeout counter: cleared on entry into ISSUE, counts through ISSUE and WAIT.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_cnt <= {CW{1'b0}};
        end else if ((r_state == ST_IDLE) && (w_next == ST_ISSUE)) begin
            r_cnt <= {CW{1'b0}};
        end else if ((r_state == ST_ISSUE) || (r_state == ST_WAIT)) begin
            r_cnt <= r_cnt + CW'(1'b1);
        end
    end

    // Registered outputs, computed from the next state so they align with it.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_s_req_valid <= {SLAVE_COUNT{1'b0}};
            r_m_res_valid <= 1'b0;
            r_m_res_err   <= 1'b0;
            r_m_res_rdata <= {DW{1'b0}};
        end else begin
            r_s_req_valid <= (w_next == ST_ISSUE) ? w_tgt_onehot : {SLAVE_COUNT{1'b0}};
            r_m_res_valid <= (w_next == ST_RESP);
            if (w_load_res) begin
                r_m_res_err   <= w_res_err;
                r_m_res_rdata <= w_res_rdata;
            end
        end
    end

    assign bus.m_req_ready = w_ready;
    assign bus.m_res_valid = r_m_res_valid;
    assign bus.m_res_err   = r_m_res_err;
    assign bus.m_res_rdata = r_m_res_rdata;
    assign bus.s_req_valid = r_s_req_valid;
    assign bus.s_req_addr  = r_addr;
    assign bus.s_req_wen   = r_wen;
    assign bus.s_req_wdata = r_wdata;
    assign bus.s_req_wstrb = r_wstrb;

endmodule

// File: tb/tb_minibus_router.sv
// -----------------------------------------------------------------------------
// tb_minibus_router
// Directed and randomized stimulus for minibus_router. Each transaction's
// target, response cycle, s_req_valid window and response payload are derived
// from the address map and the slave's ready/response cycles.
// -----------------------------------------------------------------------------
module tb_minibus_router;
    localparam int          NS  = 4;
    localparam int          TMO = 8;
    localparam logic [31:0] ERR = 32'hDEAD_BEEF;

    logic clk  = 1'b0;
    logic nrst = 1'b1;

    int n_pass = 0;
    int n_fail = 0;

    logic [31:0] ms [NS];
    logic [31:0] me [NS];

    minibus_router_if #(.SLAVE_COUNT(NS), .AW(32), .DW(32)) bus ();

    minibus_router #(
        .SLAVE_COUNT(NS),
        .AW         (32),
        .DW         (32),
        .TIMEOUT    (TMO),
        .ERR_DATA   (ERR)
    ) dut (
        .clk (clk),
        .nrst(nrst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        assert (obs === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_map();
        for (int i = 0; i < NS; i++) begin
            bus.map_start[i*32 +: 32] = ms[i];
            bus.map_end[i*32 +: 32]   = me[i];
        end
    endtask

    task automatic idle_inputs();
        bus.m_req_valid = 1'b0;
        bus.s_req_ready = 4'b0000;
        bus.s_res_valid = 4'b0000;
        bus.s_res_err   = 4'b0000;
        bus.s_res_rdata = 128'd0;
    endtask

    // One transaction starting in the current cycle (cycle 0 = acceptance cycle).
    // r: cycle the target asserts ready, p: cycle it asserts its response.
    task automatic do_txn(input logic [31:0] addr, input logic wen, input logic [31:0] wdata,
                          input logic [3:0] wstrb, input int r, input int p,
                          input logic [31:0] srd, input logic serr, input int extra,
                          input bit scramble);
        int          tgt;
        int          resp;
        int          issue_last;
        logic [31:0] edata;
        logic        eerr;
        logic [3:0]  oh;
        logic [3:0]  rdy;
        logic [3:0]  vld;
        logic [3:0]  er;

        // Reference: lowest index whose non-empty window contains addr.
        tgt = -1;
        for (int i = 0; i < NS; i++) begin
            if (tgt < 0 && ms[i] < me[i] && addr >= ms[i] && addr < me[i]) tgt = i;
        end
        oh = (tgt >= 0) ? 4'(1 << tgt) : 4'b0000;
        if (tgt < 0) begin
            resp = 1; issue_last = 0; edata = ERR; eerr = 1'b1;
        end else if (r <= TMO && p > r && p <= TMO + 1) begin
            resp = p + 1; issue_last = r; edata = srd; eerr = serr;
        end else begin
            resp = TMO + 2; issue_last = (r <= TMO) ? r : TMO + 1; edata = ERR; eerr = 1'b1;
        end

        set_map();
        check("ready_before_accept", 64'(bus.m_req_ready), 64'(1'b1));
        bus.m_req_valid = 1'b1;
        bus.m_req_addr  = addr;
        bus.m_req_wen   = wen;
        bus.m_req_wdata = wdata;
        bus.m_req_wstrb = wstrb;
        @(posedge clk); #1;
        bus.m_req_valid = 1'b0;
        bus.m_req_addr  = $urandom();
        bus.m_req_wen   = 1'($urandom());
        bus.m_req_wdata = $urandom();
        bus.m_req_wstrb = 4'($urandom());
        if (scramble) begin
            bus.map_start = {$urandom(), $urandom(), $urandom(), $urandom()};
            bus.map_end   = {$urandom(), $urandom(), $urandom(), $urandom()};
        end

        for (int k = 1; k <= resp + extra; k++) begin
            rdy = 4'($urandom());
            vld = 4'($urandom());
            er  = 4'($urandom());
            bus.s_res_rdata = {$urandom(), $urandom(), $urandom(), $urandom()};
            if (tgt >= 0) begin
                rdy[tgt] = (k == r);
                vld[tgt] = (k == p);
                er[tgt]  = serr;
                bus.s_res_rdata[tgt*32 +: 32] = srd;
            end
            bus.s_req_ready = rdy;
            bus.s_res_valid = vld;
            bus.s_res_err   = er;
            #1;
            check("s_req_valid", 64'(bus.s_req_valid), 64'((k <= issue_last) ? oh : 4'b0000));
            check("m_res_valid", 64'(bus.m_res_valid), 64'(k == resp));
            check("m_req_ready", 64'(bus.m_req_ready), 64'(k > resp));
            if (k == 1 || k == resp) begin
                check("s_req_addr",  64'(bus.s_req_addr),  64'(addr));
                check("s_req_wen",   64'(bus.s_req_wen),   64'(wen));
                check("s_req_wdata", 64'(bus.s_req_wdata), 64'(wdata));
                check("s_req_wstrb", 64'(bus.s_req_wstrb), 64'(wstrb));
            end
            if (k == resp) begin
                check("m_res_rdata", 64'(bus.m_res_rdata), 64'(edata));
                check("m_res_err",   64'(bus.m_res_err),   64'(eerr));
            end
            @(posedge clk); #1;
        end
        idle_inputs();
    endtask

    initial begin
        logic [31:0] addr;
        int          r;
        int          p;
        int          j;

        idle_inputs();
        bus.m_req_addr  = 32'd0;
        bus.m_req_wen   = 1'b0;
        bus.m_req_wdata = 32'd0;
        bus.m_req_wstrb = 4'd0;
        for (int i = 0; i < NS; i++) begin
            ms[i] = 32'd0;
            me[i] = 32'd0;
        end
        set_map();

        // Reset with random inputs on every port.
        #1 nrst = 1'b0;
        bus.m_req_valid = 1'b1;
        bus.m_req_addr  = $urandom();
        bus.m_req_wen   = 1'b1;
        bus.m_req_wdata = $urandom();
        bus.m_req_wstrb = 4'($urandom());
        bus.s_req_ready = 4'($urandom());
        bus.s_res_valid = 4'b1111;
        bus.s_res_err   = 4'($urandom());
        bus.s_res_rdata = {$urandom(), $urandom(), $urandom(), $urandom()};
        bus.map_start   = {$urandom(), $urandom(), $urandom(), $urandom()};
        bus.map_end     = {$urandom(), $urandom(), $urandom(), $urandom()};
        repeat (2) @(posedge clk);
        #1;
        check("rst_m_req_ready", 64'(bus.m_req_ready), 64'(1'b0));
        check("rst_m_res_valid", 64'(bus.m_res_valid), 64'(1'b0));
        check("rst_m_res_err",   64'(bus.m_res_err),   64'(1'b0));
        check("rst_m_res_rdata", 64'(bus.m_res_rdata), 64'(32'd0));
        check("rst_s_req_valid", 64'(bus.s_req_valid), 64'(4'd0));
        check("rst_s_req_addr",  64'(bus.s_req_addr),  64'(32'd0));
        check("rst_s_req_wen",   64'(bus.s_req_wen),   64'(1'b0));
        check("rst_s_req_wdata", 64'(bus.s_req_wdata), 64'(32'd0));
        check("rst_s_req_wstrb", 64'(bus.s_req_wstrb), 64'(4'd0));
        idle_inputs();
        nrst = 1'b1;
        #1;
        check("ready_after_rst", 64'(bus.m_req_ready), 64'(1'b1));
        @(posedge clk); #1;

        // Read hit on slave1, fastest slave.
        ms[0] = 32'h0;    me[0] = 32'h0;
        ms[1] = 32'h1000; me[1] = 32'h2000;
        ms[2] = 32'h2000; me[2] = 32'h3000;
        ms[3] = 32'h0;    me[3] = 32'h0;
        do_txn(32'h0000_1FFC, 1'b0, 32'h0, 4'hF, 1, 2, 32'hA5A5_0001, 1'b0, 0, 1'b0);
        // Window end is exclusive: 0x2000 belongs to slave2.
        do_txn(32'h0000_2000, 1'b0, 32'h0, 4'hF, 1, 2, 32'hA5A5_0002, 1'b0, 0, 1'b0);
        // Overlap: slave0 and slave3 both cover 0x0, slave0 wins.
        ms[0] = 32'h0; me[0] = 32'h100;
        ms[3] = 32'h0; me[3] = 32'h1000;
        do_txn(32'h0000_0000, 1'b0, 32'h0, 4'hF, 2, 4, 32'hA5A5_0003, 1'b0, 0, 1'b0);
        // Unmapped address.
        do_txn(32'hFFFF_0000, 1'b0, 32'h0, 4'hF, 1, 2, 32'h1111_1111, 1'b0, 0, 1'b0);
        // Timeout with a slave that never becomes ready; late response in cycle 12.
        do_txn(32'h0000_1800, 1'b0, 32'h0, 4'hF, 99, 12, 32'h2222_2222, 1'b0, 2, 1'b0);
        // Response in the exact timeout cycle wins; write with partial strobes.
        do_txn(32'h0000_2004, 1'b1, 32'hCAFE_F00D, 4'b0011, 1, TMO + 1, 32'h1234_5678, 1'b1, 0, 1'b0);
        // Three back-to-back reads.
        do_txn(32'h0000_1004, 1'b0, 32'h0, 4'hF, 1, 2, 32'hB0B0_0001, 1'b0, 0, 1'b0);
        do_txn(32'h0000_2008, 1'b0, 32'h0, 4'hF, 1, 3, 32'hB0B0_0002, 1'b0, 0, 1'b0);
        do_txn(32'h0000_0010, 1'b0, 32'h0, 4'hF, 2, 3, 32'hB0B0_0003, 1'b0, 0, 1'b0);

        // Reset while in WAIT: no response, IDLE afterwards.
        set_map();
        bus.m_req_valid = 1'b1;
        bus.m_req_addr  = 32'h0000_1800;
        bus.m_req_wen   = 1'b0;
        @(posedge clk); #1;
        bus.m_req_valid = 1'b0;
        bus.s_req_ready = 4'b0010;
        @(posedge clk); #1;
        bus.s_req_ready = 4'b0000;
        bus.s_res_valid = 4'b0010;
        bus.s_res_rdata = {4{32'h3333_3333}};
        nrst = 1'b0;
        #1;
        check("midrst_m_res_valid", 64'(bus.m_res_valid), 64'(1'b0));
        check("midrst_s_req_valid", 64'(bus.s_req_valid), 64'(4'd0));
        check("midrst_m_req_ready", 64'(bus.m_req_ready), 64'(1'b0));
        repeat (2) @(posedge clk);
        #1;
        nrst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            check("postrst_m_res_valid", 64'(bus.m_res_valid), 64'(1'b0));
            check("postrst_s_req_valid", 64'(bus.s_req_valid), 64'(4'd0));
            check("postrst_m_req_ready", 64'(bus.m_req_ready), 64'(1'b1));
            @(posedge clk); #1;
            bus.s_res_valid = 4'b0000;
        end

        // Randomized transactions with random maps, delays and mid-flight map changes.
        for (int t = 0; t < 40; t++) begin
            for (int i = 0; i < NS; i++) begin
                ms[i] = 32'($urandom_range(0, 15)) << 12;
                me[i] = ms[i] + (32'($urandom_range(0, 3)) << 12);
                if ($urandom_range(0, 7) == 0) begin
                    me[i] = ms[i];
                    ms[i] = ms[i] + 32'h800;
                end
            end
            j = $urandom_range(0, NS - 1);
            if ($urandom_range(0, 4) == 0) addr = $urandom();
            else addr = ms[j] + 32'($urandom_range(0, 32'h1FFF));
            r = $urandom_range(1, 10);
            p = r + $urandom_range(0, 4);
            do_txn(addr, 1'($urandom()), $urandom(), 4'($urandom()), r, p, $urandom(),
                   1'($urandom()), $urandom_range(0, 1), 1'($urandom()));
        end

        $display("%0d/%0d checks passed", n_pass, n_pass + n_fail);
        $finish;
    end

endmodule
